alu_arbiter: RTL
================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared W-bit ALU. It accepts operand/opcode transactions from two independent clients over valid/ready channels and drives the ALU from registered operands. It captures the ALU result and flags into a response register and returns them to the issuing client over a valid/ready response channel. It sits between the two datapath clients and the single combinational ALU instance.

## Interface
- W, 32, datapath width; must match the attached ALU.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  client n offers a transaction.
- req0_ready / req1_ready  out  1  arbiter accepts client n this cycle.
- req0_a, req0_b / req1_a, req1_b  in  W  operands: a goes to ALU R2, b goes to ALU R3.
- req0_op / req1_op  in  3  ALU opcode: 000 mov, 001 not, 010 add, 011 nor, 100 sub, 101 nand, 110 and, 111 slt.
- rsp0_valid / rsp1_valid  out  1  response for client n is held.
- rsp0_ready / rsp1_ready  in  1  client n takes the response.
- rsp_result  out  W  captured ALU result, shared by both response channels.
- rsp_flags  out  3  captured {overflow, zero, carry}.
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_r  in  W  ALU result (combinational).
- alu_overflow, alu_zero, alu_carry  in  1  ALU flags.
- op_count  out  16  number of completed responses; wraps 0xFFFF to 0x0000.

## Operation
- FSM states:
  - IDLE (arbitrate and accept).
  - EXEC (operands stable on the ALU).
  - RESP (response held).
- IDLE:
  - Grant selection: if exactly one reqN_valid is high, grant N. If both are high, grant the client not recorded in last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational from state, both valids, and last_grant. Ready is never high outside IDLE, and never high for both clients at once.
  - On reqN_valid && reqN_ready:
    - latch a, b, and op into alu_a, alu_b, alu_op;
    - set owner=N and last_grant=N;
    - move to EXEC.
- EXEC lasts exactly one cycle. At its closing edge:
  - rsp_result <= alu_r;
  - rsp_flags <= {alu_overflow, alu_zero, alu_carry};
  - move to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rspN_valid stays 0.
  - On rsp<owner>_ready: increment op_count mod 2^16 and move to IDLE.
  - Otherwise hold result, flags, and valid indefinitely.
- The arbiter does no arithmetic. Flags pass through unmodified, including the ALU's restriction that overflow and carry are only set for opcodes 100 and 111.
- alu_a, alu_b, and alu_op are held stable from acceptance until the next acceptance. They do not return to zero.
- Request inputs are ignored outside IDLE. A client deasserting valid before it is granted is legal; no transaction is recorded.
- On rst assertion, at any time including mid-EXEC or mid-RESP:
  - any in-flight transaction is dropped with no response;
  - state=IDLE, last_grant=1, so client 0 wins the first contention;
  - all registers clear.

## Timing
- Reset values: state IDLE; rsp0_valid, rsp1_valid, rsp_result, rsp_flags, alu_a, alu_b, alu_op, and op_count all 0. reqN_ready follows the IDLE equation immediately after reset.
- Accept at edge T. EXEC occupies cycle T..T+1. The result is captured at edge T+1. rspN_valid is high from just after T+1.
- With rspN_ready held high: the response completes at edge T+2 and state is IDLE. The earliest next acceptance is edge T+3.
- Peak throughput is one transaction per 3 cycles. Each cycle of response back-pressure adds one cycle.
- Under continuous dual requests, grants strictly alternate 0,1,0,1,…
- No combinational path from rspN_ready to any output other than through the state register.

## Test plan
- Add: req0 with a=5, b=7, op=010 accepted at T → rsp0_valid at T+2 with rsp_result=12, flags=000; op_count=1 after the handshake; rsp1_valid stays 0.
- Sub overflow: req1 with a=0x80000000, b=1, op=100 → rsp1 with rsp_result=0x7FFFFFFF, overflow=1, carry=1, zero=0.
- SLT: a=0xFFFFFFFD (−3), b=2, op=111 → rsp_result=1. Then a=2, b=−3 → rsp_result=0, zero=1.
- Contention: both valids held high with distinct ops for 4 transactions after reset → grant order 0,1,0,1; each response matches its owner's operands; ready is never high for both clients.
- Back-pressure: hold rsp0_ready low for 5 cycles during RESP → rsp0_valid and rsp_result are stable, req1_ready stays 0, op_count is unchanged. Releasing rsp0_ready completes in 1 cycle.
- Reset mid-op: assert rst during EXEC → no response is issued, all outputs read 0, and op_count=0. A subsequent dual request grants client 0 first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of the two client request/response channels and the ALU port seen by alu_arbiter.
// The slave modport is the arbiter side; the master modport is the clients-plus-ALU side.
interface alu_arbiter_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [2:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req1_op;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_flags;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_r;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_carry;

    logic [15:0]  op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_r, alu_overflow, alu_zero, alu_carry,
        output op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_r, alu_overflow, alu_zero, alu_carry,
        input  op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two clients.
// Each transaction runs IDLE (accept) -> EXEC (ALU settles) -> RESP (held until taken).
module alu_arbiter #(
    parameter int W = 32
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic         owner;
    logic         last_grant;
    logic         grant;
    logic         grant_any;
    logic         ready0;
    logic         ready1;
    logic         rsp_take;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   op_q;
    logic [W-1:0] result_q;
    logic [2:0]   flags_q;
    logic         rsp0_q;
    logic         rsp1_q;
    logic [15:0]  count_q;

    // Under contention the client that did not win last time gets the grant.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign ready0   = (state == IDLE) && grant_any && !grant;
    assign ready1   = (state == IDLE) && grant_any && grant;
    assign rsp_take = owner ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready0) begin
                        a_q        <= bus.req0_a;
                        b_q        <= bus.req0_b;
                        op_q       <= bus.req0_op;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (ready1) begin
                        a_q        <= bus.req1_a;
                        b_q        <= bus.req1_b;
                        op_q       <= bus.req1_op;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= bus.alu_r;
                    flags_q  <= {bus.alu_overflow, bus.alu_zero, bus.alu_carry};
                    rsp0_q   <= ~owner;
                    rsp1_q   <= owner;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        count_q <= count_q + 16'd1;
                        rsp0_q  <= 1'b0;
                        rsp1_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response valids are one-hot or idle, and a grant is never offered to both clients.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ready0 && ready1));
            assert (!(rsp0_q && rsp1_q));
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.op_count   = count_q;
endmodule
